// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial add sequencer: state encoding and counter sizing.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter must hold 0..width without wrapping.
  function automatic int cnt_width(input int width);
    return (width < 1) ? 1 : $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// Single-bit full-adder cell with per-bit propagate (a|b) and generate (a&b).
module serial_add_ctrl_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic p,
  output logic g
);

  assign s = a ^ b ^ cin;
  assign p = a | b;
  assign g = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell reused LSB-first across WIDTH bits,
// with valid/ready handshakes on operands and result.
//
// state | meaning
// IDLE  | waiting for an operand pair; io_in_ready high (unless in reset)
// RUN   | one bit per cycle through the cell, shifting operands and sum
// DONE  | result held stable until the sink takes it
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_a,
  input  logic [WIDTH-1:0] io_in_b,
  input  logic             io_in_carry,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_sum,
  output logic             io_out_carry,
  output logic             io_out_p,
  output logic             io_out_g
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_next;
  logic             carry_q, g_q, p_q;
  logic [CW-1:0]    cnt;
  logic             cell_s, cell_p, cell_g;
  logic             accept;

  serial_add_ctrl_full_adder u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry_q),
    .s   (cell_s),
    .p   (cell_p),
    .g   (cell_g)
  );

  assign io_in_ready  = (state == IDLE) && !reset;
  assign io_out_valid = (state == DONE);
  assign accept       = io_in_valid && io_in_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (cnt == LAST_BIT) state_d = DONE;
      DONE:    if (io_out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  always_comb begin
    sum_next = sum_sr >> 1;
    sum_next[WIDTH-1] = cell_s;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      carry_q <= 1'b0;
      g_q     <= 1'b0;
      p_q     <= 1'b1;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sr    <= io_in_a;
            b_sr    <= io_in_b;
            carry_q <= io_in_carry;
            g_q     <= 1'b0;
            p_q     <= 1'b1;
            cnt     <= '0;
          end
        end
        RUN: begin
          sum_sr  <= sum_next;
          carry_q <= cell_g | (cell_p & carry_q);
          g_q     <= cell_g | (cell_p & g_q);
          p_q     <= p_q & cell_p;
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          cnt     <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign io_out_sum   = sum_sr;
  assign io_out_carry = carry_q;
  assign io_out_p     = p_q;
  assign io_out_g     = g_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl at WIDTH 1, 8 and 64 with a queue-based scoreboard.
module tb_serial_add_ctrl;

  typedef struct {
    logic [63:0] sum;
    logic        carry;
    logic        p;
    logic        g;
    logic        cin;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid [3];
  logic        out_ready [3];
  logic [63:0] in_a [3];
  logic [63:0] in_b [3];
  logic        in_cin [3];
  logic        in_ready_w [3];
  logic        out_valid_w [3];
  logic        carry_w [3];
  logic        p_w [3];
  logic        g_w [3];
  logic [0:0]  s0;
  logic [7:0]  s1;
  logic [63:0] s2;
  logic [63:0] sum_w [3];

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  always_comb begin
    sum_w[0] = {63'd0, s0};
    sum_w[1] = {56'd0, s1};
    sum_w[2] = s2;
  end

  serial_add_ctrl #(.WIDTH(1)) dut_w1 (
    .clock(clk), .reset(rst),
    .io_in_valid(in_valid[0]), .io_in_ready(in_ready_w[0]),
    .io_in_a(in_a[0][0:0]), .io_in_b(in_b[0][0:0]), .io_in_carry(in_cin[0]),
    .io_out_valid(out_valid_w[0]), .io_out_ready(out_ready[0]),
    .io_out_sum(s0), .io_out_carry(carry_w[0]), .io_out_p(p_w[0]), .io_out_g(g_w[0])
  );

  serial_add_ctrl #(.WIDTH(8)) dut_w8 (
    .clock(clk), .reset(rst),
    .io_in_valid(in_valid[1]), .io_in_ready(in_ready_w[1]),
    .io_in_a(in_a[1][7:0]), .io_in_b(in_b[1][7:0]), .io_in_carry(in_cin[1]),
    .io_out_valid(out_valid_w[1]), .io_out_ready(out_ready[1]),
    .io_out_sum(s1), .io_out_carry(carry_w[1]), .io_out_p(p_w[1]), .io_out_g(g_w[1])
  );

  serial_add_ctrl #(.WIDTH(64)) dut_w64 (
    .clock(clk), .reset(rst),
    .io_in_valid(in_valid[2]), .io_in_ready(in_ready_w[2]),
    .io_in_a(in_a[2]), .io_in_b(in_b[2]), .io_in_carry(in_cin[2]),
    .io_out_valid(out_valid_w[2]), .io_out_ready(out_ready[2]),
    .io_out_sum(s2), .io_out_carry(carry_w[2]), .io_out_p(p_w[2]), .io_out_g(g_w[2])
  );

  // Reference: plain 65-bit addition, masked to the active width.
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin);
    exp_t        e;
    logic [63:0] m;
    logic [64:0] t, t0;
    m  = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    t  = {1'b0, a & m} + {1'b0, b & m} + {64'd0, cin};
    t0 = {1'b0, a & m} + {1'b0, b & m};
    e.sum   = t[63:0] & m;
    e.carry = t[w];
    e.g     = t0[w];
    e.p     = (((a | b) & m) == m);
    e.cin   = cin;
    return e;
  endfunction

  // Drives one operand pair and returns at the first negedge with io_out_valid high.
  // lat = posedges from accept to io_out_valid, or -1 on timeout.
  task automatic op_to_done(input int idx, input logic [63:0] a, input logic [63:0] b,
                            input logic cin, output int lat);
    bit got;
    lat = -1;
    got = 0;
    @(negedge clk);
    in_a[idx] = a; in_b[idx] = b; in_cin[idx] = cin; in_valid[idx] = 1'b1;
    for (int k = 0; k < 20 && !in_ready_w[idx]; k++) @(negedge clk);
    if (!in_ready_w[idx]) begin
      in_valid[idx] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid[idx] = 1'b0;
    in_a[idx] = ~a;
    for (int k = 0; k <= 80 && !got; k++) begin
      if (out_valid_w[idx]) begin
        lat = k;
        got = 1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0;
      in_a[i] = '0; in_b[i] = '0; in_cin[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (in_ready_w[i] !== 1'b0 || out_valid_w[i] !== 1'b0) begin
        bad++;
        $display("FAIL reset_hs[%0d] in_ready=%b out_valid=%b required 0/0", i, in_ready_w[i], out_valid_w[i]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (in_ready_w[i] !== 1'b1 || out_valid_w[i] !== 1'b0 || sum_w[i] !== 64'd0 ||
          carry_w[i] !== 1'b0 || p_w[i] !== 1'b1 || g_w[i] !== 1'b0) begin
        bad++;
        $display("FAIL reset_state[%0d] rdy=%b vld=%b sum=%h c=%b p=%b g=%b required 1 0 0 0 1 0",
                 i, in_ready_w[i], out_valid_w[i], sum_w[i], carry_w[i], p_w[i], g_w[i]);
      end
    end
  endtask

  task automatic test_directed();
    logic [7:0] va [3] = '{8'h5A, 8'hFF, 8'hFF};
    logic [7:0] vb [3] = '{8'h3C, 8'h01, 8'h00};
    logic       vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] es [3] = '{8'h96, 8'h00, 8'h00};
    logic       ec [3] = '{1'b0, 1'b1, 1'b1};
    logic       ep [3] = '{1'b0, 1'b1, 1'b1};
    logic       eg [3] = '{1'b0, 1'b1, 1'b0};
    int         lat;
    exp_t       e;
    for (int i = 0; i < 3; i++) begin
      e.sum = {56'd0, es[i]}; e.carry = ec[i]; e.p = ep[i]; e.g = eg[i]; e.cin = vc[i];
      sb.push_back(e);
      op_to_done(1, {56'd0, va[i]}, {56'd0, vb[i]}, vc[i], lat);
      e = sb.pop_front();
      total++;
      if (lat !== 8) begin
        bad++;
        $display("FAIL directed_latency[%0d] got=%0d required=8", i, lat);
      end
      total++;
      if (sum_w[1] !== e.sum || carry_w[1] !== e.carry || p_w[1] !== e.p || g_w[1] !== e.g) begin
        bad++;
        $display("FAIL directed_result[%0d] sum=%h c=%b p=%b g=%b required sum=%h c=%b p=%b g=%b",
                 i, sum_w[1], carry_w[1], p_w[1], g_w[1], e.sum, e.carry, e.p, e.g);
      end
      out_ready[1] = 1'b1;
      @(negedge clk);
      out_ready[1] = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int   lat;
    exp_t e;
    sb.push_back(model(8, 64'h5A, 64'h3C, 1'b0));
    op_to_done(1, 64'h5A, 64'h3C, 1'b0, lat);
    e = sb.pop_front();
    total++;
    if (lat !== 8) begin
      bad++;
      $display("FAIL bp_latency got=%0d required=8", lat);
    end
    in_a[1] = 64'h11; in_b[1] = 64'h00; in_cin[1] = 1'b0; in_valid[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (out_valid_w[1] !== 1'b1 || in_ready_w[1] !== 1'b0 || sum_w[1] !== e.sum ||
          carry_w[1] !== e.carry || p_w[1] !== e.p || g_w[1] !== e.g) begin
        bad++;
        $display("FAIL bp_hold[%0d] vld=%b rdy=%b sum=%h c=%b p=%b g=%b required 1 0 %h %b %b %b",
                 k, out_valid_w[1], in_ready_w[1], sum_w[1], carry_w[1], p_w[1], g_w[1],
                 e.sum, e.carry, e.p, e.g);
      end
      @(negedge clk);
    end
    in_valid[1] = 1'b0;
    out_ready[1] = 1'b1;
    @(negedge clk);
    out_ready[1] = 1'b0;
    total++;
    if (in_ready_w[1] !== 1'b1 || out_valid_w[1] !== 1'b0) begin
      bad++;
      $display("FAIL bp_release rdy=%b vld=%b required 1 0", in_ready_w[1], out_valid_w[1]);
    end
    begin
      bit seen = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (out_valid_w[1] !== 1'b0) seen = 1;
      end
      total++;
      if (seen) begin
        bad++;
        $display("FAIL bp_ignored_0x11 out_valid seen=1 required 0");
      end
    end
  endtask

  task automatic test_reset_mid();
    int   lat;
    bit   seen;
    exp_t e;
    @(negedge clk);
    in_a[1] = 64'h80; in_b[1] = 64'h80; in_cin[1] = 1'b0; in_valid[1] = 1'b1;
    total++;
    if (in_ready_w[1] !== 1'b1) begin
      bad++;
      $display("FAIL rm_ready_before got=%b required 1", in_ready_w[1]);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if (out_valid_w[1] !== 1'b0 || in_ready_w[1] !== 1'b0 || sum_w[1] !== 64'd0 ||
        carry_w[1] !== 1'b0 || p_w[1] !== 1'b1 || g_w[1] !== 1'b0) begin
      bad++;
      $display("FAIL rm_in_reset vld=%b rdy=%b sum=%h c=%b p=%b g=%b required 0 0 0 0 1 0",
               out_valid_w[1], in_ready_w[1], sum_w[1], carry_w[1], p_w[1], g_w[1]);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (in_ready_w[1] !== 1'b1) begin
      bad++;
      $display("FAIL rm_idle_after in_ready=%b required 1", in_ready_w[1]);
    end
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid_w[1] !== 1'b0) seen = 1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL rm_no_result out_valid seen=1 required 0");
    end
    sb.push_back(model(8, 64'h01, 64'h02, 1'b0));
    op_to_done(1, 64'h01, 64'h02, 1'b0, lat);
    e = sb.pop_front();
    total++;
    if (lat !== 8 || sum_w[1] !== e.sum || carry_w[1] !== e.carry) begin
      bad++;
      $display("FAIL rm_next_op lat=%0d sum=%h c=%b required lat=8 sum=%h c=%b",
               lat, sum_w[1], carry_w[1], e.sum, e.carry);
    end
    out_ready[1] = 1'b1;
    @(negedge clk);
    out_ready[1] = 1'b0;
  endtask

  task automatic test_random(input int idx, input int w, input int n);
    int   accepted = 0;
    int   done = 0;
    int   cyc = 0;
    int   budget;
    exp_t e;
    sb.delete();
    budget = n * (w + 3) * 4 + 200;
    while (done < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      in_valid[idx] = (accepted < n) && ($urandom_range(0, 3) != 0);
      in_a[idx] = {$urandom, $urandom};
      in_b[idx] = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: in_a[idx] = '1;
        1: in_b[idx] = ~in_a[idx];
        default: ;
      endcase
      in_cin[idx] = 1'($urandom_range(0, 1));
      out_ready[idx] = ($urandom_range(0, 3) != 0);
      if (in_valid[idx] && in_ready_w[idx]) begin
        sb.push_back(model(w, in_a[idx], in_b[idx], in_cin[idx]));
        accepted++;
      end
      if (out_valid_w[idx] && out_ready[idx]) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL rand_w%0d_unexpected result sum=%h with empty scoreboard", w, sum_w[idx]);
        end else begin
          e = sb.pop_front();
          if (sum_w[idx] !== e.sum || carry_w[idx] !== e.carry || p_w[idx] !== e.p ||
              g_w[idx] !== e.g) begin
            bad++;
            $display("FAIL rand_w%0d[%0d] sum=%h c=%b p=%b g=%b required sum=%h c=%b p=%b g=%b",
                     w, done, sum_w[idx], carry_w[idx], p_w[idx], g_w[idx],
                     e.sum, e.carry, e.p, e.g);
          end
          total++;
          if (carry_w[idx] !== (g_w[idx] | (p_w[idx] & e.cin))) begin
            bad++;
            $display("FAIL rand_w%0d_invariant[%0d] carry=%b required G|(P&cin)=%b",
                     w, done, carry_w[idx], g_w[idx] | (p_w[idx] & e.cin));
          end
        end
        done++;
      end
    end
    in_valid[idx] = 1'b0;
    out_ready[idx] = 1'b0;
    total++;
    if (done < n) begin
      bad++;
      $display("FAIL rand_w%0d_timeout results=%0d required=%0d", w, done, n);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random(0, 1, 400);
    test_random(1, 8, 400);
    test_random(2, 64, 200);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add sequencer. Owns one single-bit full-adder cell and time-multiplexes it across the bits of a WIDTH-bit operand pair.

- Processes operands LSB-first, one bit per cycle.
- Returns the WIDTH-bit sum, carry-out and group propagate/generate.
- Sits between a valid/ready operand source and a valid/ready result sink.
- Is the area-minimal alternative to a parallel carry-lookahead adder wherever latency is not critical.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 1..64.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- io_in_valid  in  1  operand pair present.
- io_in_ready  out  1  block accepts operands; high only in IDLE with reset deasserted.
- io_in_a  in  WIDTH  operand A.
- io_in_b  in  WIDTH  operand B.
- io_in_carry  in  1  carry-in.
- io_out_valid  out  1  result present; high only in DONE.
- io_out_ready  in  1  sink accepts result.
- io_out_sum  out  WIDTH  A+B+cin mod 2^WIDTH.
- io_out_carry  out  1  carry-out.
- io_out_p  out  1  group propagate, AND over bits of (a|b).
- io_out_g  out  1  group generate, carry-out with carry-in forced 0.

## Operation
State machine with three states:
- IDLE -> RUN on io_in_valid & io_in_ready. At the same edge:
  - latch a and b into shift registers;
  - carry reg <= io_in_carry, G reg <= 0, P reg <= 1, bit counter <= 0.
- RUN, one bit per cycle. The cell sees a_sr[0], b_sr[0] and carry reg. At each edge:
  - sum_sr <= {s, sum_sr[WIDTH-1:1]};
  - carry reg <= g | (p & carry);
  - G <= g | (p & G);
  - P <= P & p;
  - shift a_sr and b_sr right by 1;
  - counter += 1.
  - When the counter reaches WIDTH-1 at that edge, go to DONE.
- DONE holds all result registers stable. Go to IDLE on io_out_ready.

Outputs and fields:
- io_out_sum = sum_sr.
- io_out_carry = carry reg.
- io_out_p = P.
- io_out_g = G.
- Cell p = a|b and g = a&b, so io_out_carry == G | (P & cin) always holds. The bench checks this invariant.
- The counter is $clog2(WIDTH+1) bits and never wraps.
- io_in_valid and operand changes outside IDLE are ignored. Operands are sampled only at the accept edge.

Reset (asynchronous, takes effect immediately in any state, including mid-RUN):
- state = IDLE.
- All shift, carry, G and counter registers = 0; P = 1.
- io_out_valid = 0, io_in_ready = 0 while reset is high.
- A partially computed result is discarded. It is never presented.

## Timing
- Accept at edge T0.
- RUN occupies edges T1..TWIDTH.
- io_out_valid rises after edge TWIDTH: latency WIDTH cycles from accept.
- For WIDTH=1: RUN lasts one edge, then DONE.
- Result handshake completes at the first edge with io_out_valid & io_out_ready. io_in_ready rises the cycle after.
- Minimum initiation interval is WIDTH+2 cycles: RUN×WIDTH + DONE + IDLE.
- There is no DONE->RUN bypass.
- io_in_ready and io_out_valid are registered-state decodes with no combinational path from io_in_valid or io_out_ready.
- io_in_ready is additionally gated by reset.

## Structure
- Shared package serial_add_pkg holds:
  - the state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the counter-width function.
- One sub-module: the team's existing FullAdder cell, instantiated once.
- Sequencing, shift registers and P/G accumulation stay in serial_add_ctrl.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0 -> after 8 cycles sum=0x96, carry=0, p=0, g=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, carry=1, p=1, g=1.
- a=0xFF, b=0x00, cin=1 -> sum=0x00, carry=1, p=1, g=0 (pure propagate).
- Backpressure:
  - hold io_out_ready=0 for 5 cycles in DONE -> io_out_valid=1 and sum/carry/p/g unchanged throughout, io_in_ready=0;
  - a new io_in_valid pulse with a=0x11 is not accepted.
- Reset mid-operation:
  - assert reset at edge T3 of a=0x80, b=0x80 -> io_out_valid=0 immediately, state IDLE, no result emitted;
  - after release, a=0x01, b=0x02, cin=0 -> sum=0x03, carry=0.
- Random sweep: 1000 operand triples at WIDTH=1, 8 and 64 with random ready/valid gaps -> sum/carry match the reference model, and carry == G | (P & cin) on every result.
